sar_adc_ctrl: RTL and testbench

- Successive-approximation ADC controller; the input-side counterpart to the output-mode FSM.
- Owns the R2R ladder while the R2R path is enabled. Drives trial codes onto the ladder and samples the external analog comparator.
- Returns one WIDTH-bit conversion per start request over a valid/ready handshake to downstream logic.

---
 rtl/sar_adc_ctrl.sv | 105 ++++++++++
 tb/tb_sar_adc_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: drives trial codes onto the R2R ladder,
// samples the synchronized comparator and hands each result downstream.
module sar_adc_ctrl #(
   parameter int WIDTH         = 8,
   parameter int SETTLE_CYCLES = 4,
   parameter int SYNC_STAGES   = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             r2r_enable,
   input  logic             start,
   input  logic             comp_in,
   output logic [WIDTH-1:0] dac_code,
   output logic             busy,
   output logic [WIDTH-1:0] sample,
   output logic             sample_valid,
   input  logic             sample_ready
);

   // Ladder settle time plus comparator synchronizer delay, per trial bit.
   localparam int T     = SETTLE_CYCLES + SYNC_STAGES;
   localparam int CNT_W = $clog2(T + 1);
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, SETTLE, COMPARE, DONE} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   comp_s;
   logic [CNT_W-1:0]       settle_cnt;
   logic [IDX_W-1:0]       bit_idx;
   logic [WIDTH-1:0]       cur_mask;
   logic [WIDTH-1:0]       code_kept;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], comp_in};
   end

   assign comp_s    = sync_q[SYNC_STAGES-1];
   assign cur_mask  = WIDTH'(1) << bit_idx;
   assign code_kept = comp_s ? dac_code : (dac_code & ~cur_mask);
   assign busy      = (state == SETTLE) || (state == COMPARE);

   // Handshake: sample/sample_valid stay stable while sample_valid is high, and the
   // result transfers on the rising edge where sample_valid && sample_ready.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         dac_code     <= '0;
         sample       <= '0;
         sample_valid <= 1'b0;
         settle_cnt   <= '0;
         bit_idx      <= '0;
      end else begin
         case (state)
            IDLE: begin
               dac_code <= '0;
               if (start && r2r_enable) begin
                  bit_idx    <= IDX_W'(WIDTH - 1);
                  dac_code   <= WIDTH'(1) << (WIDTH - 1);
                  settle_cnt <= CNT_W'(T - 1);
                  state      <= SETTLE;
               end
            end
            SETTLE: begin
               if (!r2r_enable) begin
                  dac_code <= '0;
                  state    <= IDLE;
               end else if (settle_cnt == '0) begin
                  state <= COMPARE;
               end else begin
                  settle_cnt <= settle_cnt - CNT_W'(1);
               end
            end
            COMPARE: begin
               if (!r2r_enable) begin
                  dac_code <= '0;
                  state    <= IDLE;
               end else if (bit_idx != '0) begin
                  dac_code   <= code_kept | (cur_mask >> 1);
                  bit_idx    <= bit_idx - IDX_W'(1);
                  settle_cnt <= CNT_W'(T - 1);
                  state      <= SETTLE;
               end else begin
                  dac_code     <= code_kept;
                  sample       <= code_kept;
                  sample_valid <= 1'b1;
                  state        <= DONE;
               end
            end
            DONE: begin
               // r2r_enable deliberately ignored so a finished result is never dropped.
               if (sample_ready) begin
                  sample_valid <= 1'b0;
                  dac_code     <= '0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: directed scenarios plus random traffic, all checked each
// cycle against a behavioural SAR model driven by an ideal comparator.
module tb_sar_adc_ctrl;

   localparam int W       = 8;
   localparam int SC      = 4;
   localparam int SS      = 2;
   localparam int T       = SC + SS;
   localparam int BIT_CYC = T + 1;
   localparam int LAT     = W * BIT_CYC;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         r2r_enable = 1'b0;
   logic         start = 1'b0;
   logic         sample_ready = 1'b0;
   logic [W-1:0] vin = '0;
   logic         comp_in;
   logic [W-1:0] dac_code;
   logic [W-1:0] sample;
   logic         busy;
   logic         sample_valid;

   assign comp_in = (vin >= dac_code);

   sar_adc_ctrl #(.WIDTH(W), .SETTLE_CYCLES(SC), .SYNC_STAGES(SS)) dut (
      .clk(clk), .reset(reset), .r2r_enable(r2r_enable), .start(start),
      .comp_in(comp_in), .dac_code(dac_code), .busy(busy), .sample(sample),
      .sample_valid(sample_valid), .sample_ready(sample_ready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Trial code k of a binary search for v: bits above are already decided.
   function automatic logic [W-1:0] sar_trial(input logic [W-1:0] v, input int k);
      logic [W-1:0] code;
      logic [W-1:0] t;
      code = '0;
      for (int b = W - 1; b >= 0; b--) begin
         t = code | (W'(1) << b);
         if (b == W - 1 - k) return t;
         if (v >= t) code = t;
      end
      return code;
   endfunction

   // Model: 0 idle, 1 converting (m_cyc cycles since accept), 2 holding a result.
   int           m_phase = 0;
   int           m_cyc = 0;
   logic [W-1:0] m_vin = '0;
   logic [W-1:0] m_sample = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_phase  <= 0;
         m_cyc    <= 0;
         m_sample <= '0;
      end else begin
         case (m_phase)
            0: if (start && r2r_enable) begin
                  m_phase <= 1;
                  m_cyc   <= 0;
                  m_vin   <= vin;
               end
            1: if (!r2r_enable) m_phase <= 0;
               else if (m_cyc + 1 == LAT) begin
                  m_phase  <= 2;
                  m_sample <= m_vin;
               end else m_cyc <= m_cyc + 1;
            default: if (sample_ready) m_phase <= 0;
         endcase
      end
   end

   function automatic logic [W-1:0] exp_dac();
      if (m_phase == 1) return sar_trial(m_vin, m_cyc / BIT_CYC);
      if (m_phase == 2) return m_vin;
      return '0;
   endfunction

   always @(negedge clk) begin
      chk("dac_code", 32'(dac_code), 32'(exp_dac()));
      chk("busy", 32'(busy), 32'(m_phase == 1));
      chk("sample_valid", 32'(sample_valid), 32'(m_phase == 2));
      chk("sample", 32'(sample), 32'(m_sample));
   end

   task automatic do_conv(input logic [W-1:0] v, output logic [W-1:0] res, output int lat);
      vin = v;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      lat = 0;
      while (!sample_valid && lat < 4 * LAT) begin
         tick(1);
         lat++;
      end
      res = sample;
      if (sample_ready) tick(1);
   endtask

   logic [W-1:0] a5_exp [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
   logic [W-1:0] bvals [3]  = '{8'h00, 8'hFF, 8'h80};
   logic [W-1:0] trials [8] = '{default: '0};
   logic [W-1:0] res;
   int           lat;
   int           busy_cnt;
   logic         seen_valid;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      // Reset state
      reset = 1'b1;
      tick(3);
      chk("reset_dac", 32'(dac_code), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_valid", 32'(sample_valid), 0);
      chk("reset_sample", 32'(sample), 0);
      reset = 1'b0;
      r2r_enable = 1'b1;
      sample_ready = 1'b1;
      tick(2);

      for (int k = 0; k < W; k++)
         chk("model_trial_a5", 32'(sar_trial(8'hA5, k)), 32'(a5_exp[k]));

      // Reference conversion of 0xA5 with trial sequence and latency
      vin = 8'hA5;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      lat = 0;
      busy_cnt = busy ? 1 : 0;
      trials[0] = dac_code;
      while (!sample_valid && lat < 4 * LAT) begin
         tick(1);
         lat++;
         if (lat % BIT_CYC == 0 && lat / BIT_CYC < W) trials[lat / BIT_CYC] = dac_code;
         if (busy) busy_cnt++;
      end
      chk("a5_latency", lat, 56);
      chk("a5_busy_cycles", busy_cnt, 56);
      chk("a5_sample", 32'(sample), 'hA5);
      for (int k = 0; k < W; k++) chk("a5_trial", 32'(trials[k]), 32'(a5_exp[k]));
      tick(1);
      chk("a5_handshake_valid", 32'(sample_valid), 0);
      chk("a5_idle_dac", 32'(dac_code), 0);

      // Boundary codes
      for (int i = 0; i < 3; i++) begin
         do_conv(bvals[i], res, lat);
         chk("boundary_sample", 32'(res), 32'(bvals[i]));
         chk("boundary_latency", lat, LAT);
      end

      // Backpressure with an ignored start during the hold
      sample_ready = 1'b0;
      do_conv(8'h3C, res, lat);
      chk("bp_sample", 32'(res), 'h3C);
      for (int i = 0; i < 20; i++) begin
         start = (i == 10);
         tick(1);
      end
      start = 1'b0;
      chk("bp_hold_sample", 32'(sample), 'h3C);
      chk("bp_hold_dac", 32'(dac_code), 'h3C);
      chk("bp_hold_valid", 32'(sample_valid), 1);
      sample_ready = 1'b1;
      tick(1);
      chk("bp_release_valid", 32'(sample_valid), 0);
      chk("bp_release_dac", 32'(dac_code), 0);
      tick(3);
      chk("bp_start_ignored", 32'(busy), 0);

      // Gating and abort
      r2r_enable = 1'b0;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(2);
      chk("gated_busy", 32'(busy), 0);
      chk("gated_dac", 32'(dac_code), 0);
      r2r_enable = 1'b1;
      vin = 8'h77;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(20);
      r2r_enable = 1'b0;
      tick(1);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_dac", 32'(dac_code), 0);
      seen_valid = 1'b0;
      for (int i = 0; i < LAT + 10; i++) begin
         tick(1);
         if (sample_valid) seen_valid = 1'b1;
      end
      chk("abort_no_valid", 32'(seen_valid), 0);
      chk("abort_sample_kept", 32'(sample), 'h3C);
      r2r_enable = 1'b1;
      do_conv(8'hC3, res, lat);
      chk("reenable_sample", 32'(res), 'hC3);

      // Reset mid-conversion
      vin = 8'h99;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(30);
      reset = 1'b1;
      #1;
      chk("midreset_dac", 32'(dac_code), 0);
      chk("midreset_busy", 32'(busy), 0);
      chk("midreset_valid", 32'(sample_valid), 0);
      chk("midreset_sample", 32'(sample), 0);
      tick(1);
      reset = 1'b0;
      tick(1);
      do_conv(8'h5A, res, lat);
      chk("postreset_sample", 32'(res), 'h5A);
      chk("postreset_latency", lat, 56);

      // Back-to-back with start held high through busy and the handshake
      vin = 8'h11;
      start = 1'b1;
      tick(1);
      lat = 0;
      while (!sample_valid && lat < 4 * LAT) begin
         tick(1);
         lat++;
      end
      chk("b2b_first_sample", 32'(sample), 'h11);
      chk("b2b_first_latency", lat, 56);
      tick(1);
      chk("b2b_start_dropped_in_done", 32'(busy), 0);
      vin = 8'hEE;
      tick(1);
      start = 1'b0;
      lat = 0;
      while (!sample_valid && lat < 4 * LAT) begin
         tick(1);
         lat++;
      end
      chk("b2b_second_sample", 32'(sample), 'hEE);
      chk("b2b_second_latency", lat, 56);
      tick(4);
      chk("b2b_no_extra", 32'(busy), 0);

      // Random traffic; vin only changes while the model is idle
      for (int i = 0; i < 1500; i++) begin
         if (m_phase == 0) vin = W'($urandom_range(0, 255));
         start        = ($urandom_range(0, 3) == 0);
         sample_ready = ($urandom_range(0, 2) != 0);
         r2r_enable   = ($urandom_range(0, 299) != 0);
         tick(1);
      end
      start = 1'b0;
      r2r_enable = 1'b1;
      sample_ready = 1'b1;
      tick(LAT + 5);
      chk("final_idle_busy", 32'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
